// File: rtl/o_move_engine.sv
// Tic-tac-toe O opponent: scans for a winning square, then a blocking square, then a preference square.
// Optional blocking phase is compiled in with `define O_ENGINE_BLOCK_EN.
module o_move_engine #(
  parameter int unsigned THINK_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] x,
  input  logic [8:0] o,
  input  logic       winner,
  output logic [8:0] o_move,
  output logic       busy,
  output logic [1:0] move_kind
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN,
`ifdef O_ENGINE_BLOCK_EN
    S_BLOCK,
`endif
    S_PREF,
    S_DRIVE
  } state_t;

  localparam logic [7:0][8:0] LINES = {
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };
  localparam logic [8:0][3:0] PREF_ORDER = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
  };

  state_t     state, state_d;
  logic [3:0] idx, idx_d;
  logic [7:0] cnt, cnt_d;
  logic [8:0] snap_x, snap_o;
  logic [3:0] sel_sq;
  logic [1:0] sel_kind;
  logic [8:0] occ;
  logic       o_turn, go, abort, pref_found;
  logic [3:0] pref_sq;

  // Square sq is a hit when it is empty and completes some line with two squares of board.
  function automatic logic line_hit(input logic [8:0] board, input logic [8:0] taken,
                                    input logic [3:0] sq);
    logic       r;
    logic [8:0] sq_bit;
    r      = 1'b0;
    sq_bit = 9'b1 << sq;
    for (int unsigned l = 0; l < 8; l++) begin
      if ((LINES[l] & sq_bit) != '0 && (board & LINES[l]) == (LINES[l] & ~sq_bit))
        r = 1'b1;
    end
    return r & ~|(taken & sq_bit);
  endfunction

  always_comb begin
    occ    = x | o;
    o_turn = $countones(x) > $countones(o);
    go     = enable & o_turn & ~winner;
    abort  = winner | ~enable | ~o_turn | (x != snap_x) | (o != snap_o);

    pref_found = 1'b0;
    pref_sq    = '0;
    for (int unsigned p = 0; p < 9; p++) begin
      if (!pref_found && !occ[PREF_ORDER[p]]) begin
        pref_found = 1'b1;
        pref_sq    = PREF_ORDER[p];
      end
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt;
    sel_sq   = idx;
    sel_kind = 2'd2;
    case (state)
      S_IDLE: begin
        idx_d = '0;
        if (!go) begin
          cnt_d = '0;
        end else if (cnt == 8'(THINK_CYCLES)) begin
          cnt_d   = '0;
          state_d = S_WIN;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_WIN: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (line_hit(o, occ, idx)) begin
          state_d  = S_DRIVE;
          sel_kind = 2'd0;
          idx_d    = '0;
        end else if (idx == 4'd8) begin
`ifdef O_ENGINE_BLOCK_EN
          state_d = S_BLOCK;
`else
          state_d = S_PREF;
`endif
          idx_d = '0;
        end else begin
          idx_d = idx + 4'd1;
        end
      end
`ifdef O_ENGINE_BLOCK_EN
      S_BLOCK: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (line_hit(x, occ, idx)) begin
          state_d  = S_DRIVE;
          sel_kind = 2'd1;
          idx_d    = '0;
        end else if (idx == 4'd8) begin
          state_d = S_PREF;
          idx_d   = '0;
        end else begin
          idx_d = idx + 4'd1;
        end
      end
`endif
      S_PREF: begin
        sel_sq = pref_sq;
        if (abort || !pref_found) state_d = S_IDLE;
        else                      state_d = S_DRIVE;
      end
      S_DRIVE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      snap_x    <= '0;
      snap_o    <= '0;
      o_move    <= '0;
      busy      <= 1'b0;
      move_kind <= 2'd2;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      if (state == S_IDLE) begin
        snap_x <= x;
        snap_o <= o;
      end
      o_move <= (state_d == S_DRIVE) ? (9'b1 << sel_sq) : '0;
      busy   <= (state_d != S_IDLE);
      if (state_d == S_DRIVE) move_kind <= sel_kind;
    end
  end

endmodule
